// File: rtl/ori_hist_ctrl_pkg.sv
// Shared constants, FSM encoding and saturating arithmetic for the
// orientation-histogram controller.
package ori_hist_ctrl_pkg;

  localparam int unsigned NBINS = 32;
  localparam int unsigned BIN_W = 5;
  localparam int unsigned KEY_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    ACC,
    FLUSH,
    SCAN,
    DONE
  } state_e;

  // Unsigned add clamped to 2^w-1; w must be at most 32.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] sum;
    logic [32:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << w) - 33'd1;
    return (sum > lim) ? lim[31:0] : sum[31:0];
  endfunction

endpackage

// File: rtl/ori_hist_ctrl_if.sv
// Gradient-sample stream: valid/ready handshake carrying key, magnitude
// and end-of-window marker.
interface ori_hist_ctrl_if #(
  parameter int unsigned MAG_W = 8
);
  import ori_hist_ctrl_pkg::*;

  logic             s_valid;
  logic             s_ready;
  logic [KEY_W-1:0] s_key;
  logic [MAG_W-1:0] s_mag;
  logic             s_last;

  modport master (
    output s_valid, s_key, s_mag, s_last,
    input  s_ready
  );

  modport slave (
    input  s_valid, s_key, s_mag, s_last,
    output s_ready
  );

endinterface

// File: rtl/ori_peak_scan.sv
// Sequential argmax over the histogram, one bin per enabled cycle;
// strict-greater compare so ties keep the lowest index.
module ori_peak_scan
  import ori_hist_ctrl_pkg::*;
#(
  parameter int unsigned ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_scan,
  input  logic             en,
  input  logic [BIN_W-1:0] idx,
  input  logic [ACC_W-1:0] hist_val,
  output logic [BIN_W-1:0] bin,
  output logic [ACC_W-1:0] val,
  output logic             scan_done
);

  logic [BIN_W-1:0] bin_q;
  logic [ACC_W-1:0] val_q;
  logic             scan_done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q       <= '0;
      val_q       <= '0;
      scan_done_q <= 1'b0;
    end else begin
      scan_done_q <= en && (idx == BIN_W'(NBINS - 1));
      // First element seeds the running max, so an all-zero histogram yields bin 0.
      if (en && (start_scan || (hist_val > val_q))) begin
        bin_q <= idx;
        val_q <= hist_val;
      end
    end
  end

  assign bin       = bin_q;
  assign val       = val_q;
  assign scan_done = scan_done_q;

endmodule

// File: rtl/ori_hist_ctrl.sv
// Orientation-histogram controller: accumulates gradient magnitudes into
// 32 saturating bins via an external direction ROM, then reports the peak.
module ori_hist_ctrl
  import ori_hist_ctrl_pkg::*;
#(
  parameter int unsigned MAG_W = 8,
  parameter int unsigned ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  ori_hist_ctrl_if.slave   s,
  output logic [KEY_W-1:0] rom_a,
  input  logic [BIN_W-1:0] rom_spo,
  output logic             busy,
  output logic             done,
  output logic [BIN_W-1:0] peak_bin,
  output logic [ACC_W-1:0] peak_val
);

  state_e           state_q;
  logic             s_ready_q;
  logic             busy_q;
  logic             done_q;
  logic [BIN_W-1:0] peak_bin_q;
  logic [ACC_W-1:0] peak_val_q;
  logic [BIN_W-1:0] idx_q;
  logic             scan_en_q;

  logic             p1_valid_q;
  logic             p1_last_q;
  logic [MAG_W-1:0] p1_mag_q;
  logic [KEY_W-1:0] rom_a_q;

  logic [ACC_W-1:0] hist_q [NBINS];
  logic [ACC_W-1:0] hist_sum_d;

  logic             accept;
  logic             scan_first;
  logic [BIN_W-1:0] scan_bin;
  logic [ACC_W-1:0] scan_val;
  logic             scan_done;

  assign accept     = s.s_valid & s_ready_q;
  assign hist_sum_d = ACC_W'(sat_add(32'(hist_q[rom_spo]), 32'(p1_mag_q), ACC_W));
  assign scan_first = scan_en_q && (idx_q == '0);

  // Stage 1: key drives the ROM address; magnitude waits one cycle for the bin.
  always_ff @(posedge clk) begin
    if (rst) begin
      p1_valid_q <= 1'b0;
      p1_last_q  <= 1'b0;
      p1_mag_q   <= '0;
      rom_a_q    <= '0;
    end else begin
      p1_valid_q <= accept;
      if (accept) begin
        rom_a_q   <= s.s_key;
        p1_mag_q  <= s.s_mag;
        p1_last_q <= s.s_last;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || (state_q == CLR)) begin
      for (int unsigned i = 0; i < NBINS; i++) begin
        hist_q[i] <= '0;
      end
    end else if (p1_valid_q) begin
      hist_q[rom_spo] <= hist_sum_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      s_ready_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      peak_bin_q <= '0;
      peak_val_q <= '0;
      idx_q      <= '0;
      scan_en_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= CLR;
            busy_q  <= 1'b1;
          end
        end
        CLR: begin
          state_q   <= ACC;
          s_ready_q <= 1'b1;
        end
        ACC: begin
          if (accept && s.s_last) begin
            state_q   <= FLUSH;
            s_ready_q <= 1'b0;
          end
        end
        FLUSH: begin
          // The last sample's read-modify-write lands on this same edge,
          // so the histogram is final once the scan starts.
          if (!p1_valid_q || p1_last_q) begin
            state_q   <= SCAN;
            idx_q     <= '0;
            scan_en_q <= 1'b1;
          end
        end
        SCAN: begin
          if (scan_en_q) begin
            if (idx_q == BIN_W'(NBINS - 1)) begin
              scan_en_q <= 1'b0;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
          if (scan_done) begin
            state_q    <= DONE;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            peak_bin_q <= scan_bin;
            peak_val_q <= scan_val;
          end
        end
        default: begin
          state_q   <= IDLE;
          s_ready_q <= 1'b0;
          busy_q    <= 1'b0;
          scan_en_q <= 1'b0;
        end
      endcase
    end
  end

  ori_peak_scan #(
    .ACC_W (ACC_W)
  ) u_peak_scan (
    .clk        (clk),
    .rst        (rst),
    .start_scan (scan_first),
    .en         (scan_en_q),
    .idx        (idx_q),
    .hist_val   (hist_q[idx_q]),
    .bin        (scan_bin),
    .val        (scan_val),
    .scan_done  (scan_done)
  );

  assign s.s_ready = s_ready_q;
  assign rom_a     = rom_a_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign peak_bin  = peak_bin_q;
  assign peak_val  = peak_val_q;

endmodule

// File: tb/tb_ori_hist_ctrl.sv
// Scoreboard bench: two controllers (16-bit and 8-bit accumulators) run the
// same sample stream against a behavioural direction ROM and histogram model.
module tb_ori_hist_ctrl;
  import ori_hist_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  always #5 clk = ~clk;

  logic       drv_valid = 1'b0;
  logic [7:0] drv_key   = '0;
  logic [7:0] drv_mag   = '0;
  logic       drv_last  = 1'b0;

  ori_hist_ctrl_if #(.MAG_W(8)) if16 ();
  ori_hist_ctrl_if #(.MAG_W(8)) if8 ();

  assign if16.s_valid = drv_valid;
  assign if16.s_key   = drv_key;
  assign if16.s_mag   = drv_mag;
  assign if16.s_last  = drv_last;
  assign if8.s_valid  = drv_valid;
  assign if8.s_key    = drv_key;
  assign if8.s_mag    = drv_mag;
  assign if8.s_last   = drv_last;

  logic [7:0]  rom_a16, rom_a8;
  logic [4:0]  rom_spo16, rom_spo8;
  logic        busy16, busy8, done16, done8;
  logic [4:0]  pb16, pb8;
  logic [15:0] pv16;
  logic [7:0]  pv8;

  // Behavioural stand-in for the direction ROM; the listed keys are fixed points.
  function automatic logic [4:0] dir_rom(input logic [7:0] a);
    case (a)
      8'd0:    return 5'h1a;
      8'd96:   return 5'h1f;
      8'd112:  return 5'h00;
      8'd128:  return 5'h01;
      8'd144:  return 5'h02;
      8'd255:  return 5'h06;
      default: return a[7:3];
    endcase
  endfunction

  assign rom_spo16 = dir_rom(rom_a16);
  assign rom_spo8  = dir_rom(rom_a8);

  ori_hist_ctrl #(.MAG_W(8), .ACC_W(16)) u_dut16 (
    .clk(clk), .rst(rst), .start(start), .s(if16),
    .rom_a(rom_a16), .rom_spo(rom_spo16), .busy(busy16), .done(done16),
    .peak_bin(pb16), .peak_val(pv16)
  );

  ori_hist_ctrl #(.MAG_W(8), .ACC_W(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start), .s(if8),
    .rom_a(rom_a8), .rom_spo(rom_spo8), .busy(busy8), .done(done8),
    .peak_bin(pb8), .peak_val(pv8)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int bin16;
    int val16;
    int bin8;
    int val8;
    int due;
    int key;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   h16 [32];
  int   h8  [32];
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      h16[i] = 0;
      h8[i]  = 0;
    end
  endtask

  task automatic model_accept(input logic [7:0] k, input logic [7:0] m,
                              input logic l, input int acc_cyc);
    int b;
    exp_t x;
    b = int'(dir_rom(k));
    h16[b] = (h16[b] + int'(m) > 65535) ? 65535 : h16[b] + int'(m);
    h8[b]  = (h8[b] + int'(m) > 255) ? 255 : h8[b] + int'(m);
    if (l) begin
      x.bin16 = 0; x.val16 = h16[0];
      x.bin8  = 0; x.val8  = h8[0];
      for (int i = 1; i < 32; i++) begin
        if (h16[i] > x.val16) begin x.bin16 = i; x.val16 = h16[i]; end
        if (h8[i] > x.val8) begin x.bin8 = i; x.val8 = h8[i]; end
      end
      x.due = acc_cyc + 34;
      x.key = int'(k);
      sb.push_back(x);
    end
  endtask

  logic done_prev = 1'b0;

  always @(negedge clk) begin
    if (done_prev) chk("done_pulse", done16, 0);
    done_prev = done16;
    if (done16) begin
      if (sb.size() == 0) begin
        chk("spurious_done", sb.size(), 1);
      end else begin
        e = sb.pop_front();
        chk("peak_bin", pb16, e.bin16);
        chk("peak_val", pv16, e.val16);
        chk("done_cycle", cyc, e.due);
        chk("done8", done8, 1);
        chk("peak_bin8", pb8, e.bin8);
        chk("peak_val8", pv8, e.val8);
        chk("rom_a_hold", rom_a16, e.key);
      end
    end
  end

  task automatic start_window();
    @(negedge clk);
    start = 1'b1;
    model_clear();
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] k, input logic [7:0] m, input logic l);
    int n;
    n = 0;
    @(negedge clk);
    drv_valid = 1'b1;
    drv_key   = k;
    drv_mag   = m;
    drv_last  = l;
    while (!if16.s_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      chk("accept_timeout", n, 0);
      drv_valid = 1'b0;
      return;
    end
    model_accept(k, m, l, cyc + 1);
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    drv_valid = 1'b0;
    drv_last  = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) chk(tag, sb.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic rst_check(input string tag);
    chk({tag, "_ready"}, if16.s_ready, 0);
    chk({tag, "_busy"}, busy16, 0);
    chk({tag, "_done"}, done16, 0);
    chk({tag, "_rom_a"}, rom_a16, 0);
    chk({tag, "_pbin"}, pb16, 0);
    chk({tag, "_pval"}, pv16, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int extra;
    model_clear();
    repeat (3) @(negedge clk);
    rst_check("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Basic window
    start_window();
    send(8'd0, 8'd10, 1'b0);
    send(8'd128, 8'd5, 1'b0);
    send(8'd112, 8'd3, 1'b1);
    idle();
    wait_drain("basic_timeout");

    // Same-bin back-to-back accumulation
    start_window();
    for (int i = 0; i < 3; i++) send(8'd96, 8'd100, (i == 2));
    idle();
    wait_drain("samebin_timeout");

    // Saturation (8-bit instance clamps to 255)
    start_window();
    send(8'd255, 8'd200, 1'b0);
    send(8'd255, 8'd200, 1'b1);
    idle();
    wait_drain("sat_timeout");

    // Tie resolves to lowest bin
    start_window();
    send(8'd128, 8'd7, 1'b0);
    send(8'd144, 8'd7, 1'b1);
    idle();
    wait_drain("tie_timeout");

    // All-zero histogram
    start_window();
    send(8'd0, 8'd0, 1'b1);
    idle();
    wait_drain("zero_timeout");

    // Back-pressure with start pulsed mid-scan
    start_window();
    send(8'd144, 8'd20, 1'b0);
    send(8'd60, 8'd30, 1'b1);
    extra = 0;
    @(negedge clk);
    drv_valid = 1'b1;
    drv_key   = 8'd200;
    drv_mag   = 8'd50;
    drv_last  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      start = (i == 10);
      if (i == 11) chk("busy_scan", busy16, 1);
      if (if16.s_ready) extra++;
      @(negedge clk);
    end
    start = 1'b0;
    chk("no_extra_accept", extra, 0);
    idle();
    wait_drain("bp_timeout");
    repeat (40) @(negedge clk);
    chk("idle_after_bp", busy16, 0);

    // Reset mid-window
    start_window();
    send(8'd64, 8'd9, 1'b0);
    send(8'd200, 8'd4, 1'b0);
    @(negedge clk);
    drv_valid = 1'b0;
    rst = 1'b1;
    model_clear();
    @(negedge clk);
    rst_check("midrst1");
    @(negedge clk);
    rst_check("midrst2");
    rst = 1'b0;
    repeat (45) @(negedge clk);
    start_window();
    send(8'd0, 8'd1, 1'b1);
    idle();
    wait_drain("post_rst_timeout");

    repeat (40) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ori_hist_ctrl.md
Name: ori_hist_ctrl

Overview:
Orientation-histogram controller for the SIFT orientation-assignment stage. It accepts a stream of gradient samples, each carrying an 8-bit direction key and a magnitude, and drives the shared combinational direction ROM (dir10_2, 8-bit address to 5-bit bin). It accumulates each magnitude into a 32-bin histogram. After the window's last sample it scans the histogram and reports the dominant bin and its value to the keypoint-descriptor stage.

Parameters:
MAG_W, 8, gradient magnitude width.
ACC_W, 16, histogram bin accumulator width; saturating.
NBINS, 32, number of bins; fixed at 2^5, equal to the ROM data range.

Ports:
clk  in  1  system clock, all logic rising-edge.
rst  in  1  synchronous, active-high reset.
start  in  1  one-cycle pulse; begins a new window; honoured only in IDLE or DONE.
s_valid  in  1  sample valid.
s_ready  out  1  sample accepted when s_valid & s_ready.
s_key  in  8  direction key; forwarded to the ROM address.
s_mag  in  MAG_W  gradient magnitude.
s_last  in  1  marks the final sample of the window.
rom_a  out  8  direction ROM address (registered).
rom_spo  in  5  direction ROM data; combinational response to rom_a.
busy  out  1  high in CLR, ACC, FLUSH, SCAN.
done  out  1  one-cycle pulse; peak outputs valid.
peak_bin  out  5  index of the maximum bin.
peak_val  out  ACC_W  value of the maximum bin.

Behaviour:
- Reset (synchronous rst=1): state=IDLE; s_ready=0, busy=0, done=0, rom_a=0, peak_bin=0, peak_val=0; pipeline valid cleared; histogram cleared.
- States:
  - IDLE: start -> CLR.
  - CLR: 1 cycle, zeroes all NBINS accumulators in parallel; -> ACC.
  - ACC: s_ready=1. On an accepted sample with s_last=1 -> FLUSH; s_ready drops on the following cycle.
  - FLUSH: waits until the pipeline stage is empty; -> SCAN.
  - SCAN: exactly NBINS cycles, idx 0..31. Running max updates only when hist[idx] > max (strictly greater), so ties resolve to the lowest bin. -> DONE.
  - DONE: done=1 for the first cycle only; peak_bin and peak_val hold until the next CLR; start -> CLR.
- Pipeline, with E0 the accept edge:
  - At E0, p1_valid, rom_a=s_key, p1_mag and p1_last are registered.
  - During the following cycle rom_spo is valid.
  - At E1, hist[rom_spo] <= sat(hist[rom_spo] + p1_mag).
  - Back-to-back samples to the same bin need no hazard handling: the RMW completes in a single cycle.
- Arithmetic: magnitude is zero-extended to ACC_W. On overflow the sum clamps to 2^ACC_W-1.
- Latency:
  - Last sample accepted at edge E0 gives FLUSH at E0, SCAN at E1, DONE after E1+NBINS.
  - done is asserted 34 cycles after the last accept edge.
- Boundary conditions:
  - start while busy is ignored.
  - start in the same cycle as the DONE entry is ignored; it is honoured from the next cycle.
  - s_valid with s_ready=0 is not consumed; upstream holds its data.
  - An all-zero histogram reports peak_bin=0, peak_val=0.
  - rst mid-window discards all state, and no done is produced.
  - rom_a retains its last value when idle.

Decomposition:
- Shared package holds:
  - constants NBINS=32, BIN_W=5, KEY_W=8;
  - the state encoding (IDLE, CLR, ACC, FLUSH, SCAN, DONE);
  - the saturating-add function.
- One natural sub-module: ori_peak_scan (sequential argmax over NBINS with a strict-greater compare), driven by start_scan/idx and returning bin/val/scan_done.
- The ROM stays external so that dir10_2 and its sibling direction ROMs remain interchangeable.

Test Plan:
1. Basic window:
   - Stimulus: start; samples (key 0, mag 10), (key 128, mag 5), (key 112, mag 3, last).
   - Response: hist[0x1a]=10, hist[1]=5, hist[0]=3; done 34 cycles after the last accept; peak_bin=0x1a, peak_val=10.
2. Same-bin accumulation:
   - Stimulus: start; 3 back-to-back samples with key 96, mag 100 each.
   - Response: hist[0x1f]=300; peak_bin=0x1f, peak_val=300.
3. Saturation:
   - Stimulus: ACC_W=8; key 255 (bin 6), 2 samples with mag 200.
   - Response: peak_bin=6, peak_val=255.
4. Tie-break:
   - Stimulus: keys 128 and 144 (bins 1 and 2), mag 7 each.
   - Response: peak_bin=1, peak_val=7.
5. Back-pressure and ignored start:
   - Stimulus: s_valid held through FLUSH and SCAN; start pulsed during SCAN.
   - Response: no extra sample consumed; scan not restarted; single done pulse.
6. Reset mid-window:
   - Stimulus: rst in ACC after 2 samples, then a new window (key 0, mag 1, last).
   - Response: all outputs 0 during rst; no done for the aborted window; new window reports peak_bin=0x1a, peak_val=1.
